// File: rtl/alu_pkg.sv
// Shared widths, ALU control encodings and the issue-register payload for alu_issue_stage.
package alu_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned RET_W    = 16;
    localparam int unsigned CTRL_W   = 3;
    localparam int unsigned FLAG_W   = 3;
    localparam int unsigned NUM_REGS = 32;

    // ALU control codes; values outside this set are passed through unchecked.
    typedef enum logic [CTRL_W-1:0] {
        ALU_ADD = 3'h2,
        ALU_SUB = 3'h3,
        ALU_AND = 3'h4,
        ALU_OR  = 3'h5,
        ALU_NOR = 3'h6,
        ALU_XOR = 3'h7
    } alu_ctrl_e;

    // Contents of the issue register driven toward the ALU.
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } issue_t;

endpackage

// File: rtl/regfile32.sv
// 32x32 register file: two operand read ports, a debug read port, and a write
// path where the ALU writeback has priority over the load port. r0 reads as zero.
module regfile32
    import alu_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              alu_we,
    input  logic [REG_AW-1:0] alu_waddr,
    input  logic [DATA_W-1:0] alu_wdata,
    input  logic              ld_we,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Storage update; entry 0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (alu_we && (alu_waddr == REG_AW'(i))) begin
                    mem[i] <= alu_wdata;
                end else if (ld_we && (ld_addr == REG_AW'(i))) begin
                    mem[i] <= ld_data;
                end
            end
        end
    end

    // Combinational reads with r0 hardwired to zero.
    always_comb begin
        ra_data  = (ra_addr  == '0) ? '0 : mem[ra_addr];
        rb_data  = (rb_addr  == '0) ? '0 : mem[rb_addr];
        dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand fetch / issue / writeback stage around a combinational 32-bit ALU.
// Optional feature macro: ALU_ISSUE_BYPASS_EN forwards alu_out to a hazarding
// operand instead of stalling the request for one cycle.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [2:0]  req_ctrl,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [2:0]  alu_control,
    output logic        alu_valid,
    input  logic [31:0] alu_out,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    input  logic        alu_negative,
    output logic [2:0]  flags,
    output logic [15:0] retired,
    input  logic        ld_we,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data
);

    issue_t            issue_q;
    logic              valid_q;
    logic [FLAG_W-1:0] flags_q;
    logic [RET_W-1:0]  retired_q;

    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              hz_a;
    logic              hz_b;
    logic              accept;

    regfile32 u_rf (
        .clock     (clock),
        .reset_n   (reset_n),
        .alu_we    (valid_q),
        .alu_waddr (issue_q.rd),
        .alu_wdata (alu_out),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ra_addr   (req_rs),
        .ra_data   (rf_a),
        .rb_addr   (req_rt),
        .rb_data   (rf_b),
        .dbg_addr  (rd_addr),
        .dbg_data  (rd_data)
    );

    // RAW hazard against the in-flight op, then either forward or stall.
    always_comb begin
        hz_a = req_valid && valid_q && (issue_q.rd != '0) && (issue_q.rd == req_rs);
        hz_b = req_valid && valid_q && (issue_q.rd != '0) && (issue_q.rd == req_rt);
`ifdef ALU_ISSUE_BYPASS_EN
        op_a      = hz_a ? alu_out : rf_a;
        op_b      = hz_b ? alu_out : rf_b;
        req_ready = reset_n;
`else
        op_a      = rf_a;
        op_b      = rf_b;
        req_ready = reset_n && !(hz_a || hz_b);
`endif
        accept = req_valid && req_ready;
    end

    // Issue register; operands and control hold when nothing is accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            issue_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                issue_q.a    <= op_a;
                issue_q.b    <= op_b;
                issue_q.ctrl <= req_ctrl;
                issue_q.rd   <= req_rd;
            end
        end
    end

    // Retire bookkeeping: flags capture and wrapping retire counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flags_q   <= '0;
            retired_q <= '0;
        end else if (valid_q) begin
            flags_q   <= {alu_overflow, alu_zero, alu_negative};
            retired_q <= retired_q + RET_W'(1);
        end
    end

    assign alu_A       = issue_q.a;
    assign alu_B       = issue_q.b;
    assign alu_control = issue_q.ctrl;
    assign alu_valid   = valid_q;
    assign flags       = flags_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU closing the loop.
module tb_alu_issue_stage;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [2:0]  req_ctrl;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [2:0]  alu_control;
    logic        alu_valid;
    logic [31:0] alu_out;
    logic        alu_overflow;
    logic        alu_zero;
    logic        alu_negative;
    logic [2:0]  flags;
    logic [15:0] retired;
    logic        ld_we;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    int errors;
    int checks;

    alu_issue_stage dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rs       (req_rs),
        .req_rt       (req_rt),
        .req_rd       (req_rd),
        .req_ctrl     (req_ctrl),
        .alu_A        (alu_A),
        .alu_B        (alu_B),
        .alu_control  (alu_control),
        .alu_valid    (alu_valid),
        .alu_out      (alu_out),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .flags        (flags),
        .retired      (retired),
        .ld_we        (ld_we),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference ALU: signed overflow on ADD/SUB only.
    always_comb begin
        alu_out      = 32'h0;
        alu_overflow = 1'b0;
        case (alu_control)
            3'h2: begin
                alu_out      = alu_A + alu_B;
                alu_overflow = (alu_A[31] == alu_B[31]) && (alu_out[31] != alu_A[31]);
            end
            3'h3: begin
                alu_out      = alu_A - alu_B;
                alu_overflow = (alu_A[31] != alu_B[31]) && (alu_out[31] != alu_A[31]);
            end
            3'h4: alu_out = alu_A & alu_B;
            3'h5: alu_out = alu_A | alu_B;
            3'h6: alu_out = ~(alu_A | alu_B);
            3'h7: alu_out = alu_A ^ alu_B;
            default: alu_out = 32'h0;
        endcase
        alu_zero     = (alu_out == 32'h0);
        alu_negative = alu_out[31];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic peek(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        rd_addr = addr;
        #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic load(input logic [4:0] addr, input logic [31:0] data);
        ld_we   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        tick();
        ld_we   = 1'b0;
    endtask

    task automatic request(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [2:0] ctrl);
        req_valid = 1'b1;
        req_rs    = rs;
        req_rt    = rt;
        req_rd    = rd;
        req_ctrl  = ctrl;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_rs    = '0;
        req_rt    = '0;
        req_rd    = '0;
        req_ctrl  = '0;
        ld_we     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        rd_addr   = '0;

        // Reset
        tick();
        tick();
        chk("ready_in_reset", 32'(req_ready), 32'h0);
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            peek("rf_reset", 5'(i), 32'h0);
        end
        chk("valid_reset", 32'(alu_valid), 32'h0);
        chk("flags_reset", 32'(flags), 32'h0);
        chk("retired_reset", 32'(retired), 32'h0);
        chk("ready_after_reset", 32'(req_ready), 32'h1);

        // Simple ADD r3 = r1 + r2
        load(5'd1, 32'd5);
        load(5'd2, 32'd3);
        peek("r1_load", 5'd1, 32'd5);
        request(5'd1, 5'd2, 5'd3, 3'h2);
        #1;
        chk("ready_add", 32'(req_ready), 32'h1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("add_A", alu_A, 32'd5);
        chk("add_B", alu_B, 32'd3);
        chk("add_ctrl", 32'(alu_control), 32'h2);
        chk("add_valid", 32'(alu_valid), 32'h1);
        tick();
        peek("add_r3", 5'd3, 32'd8);
        chk("add_flags", 32'(flags), 32'h0);
        chk("add_retired", 32'(retired), 32'd1);
        chk("add_valid_drop", 32'(alu_valid), 32'h0);
        chk("hold_A", alu_A, 32'd5);

        // RAW hazard: ADD r3 = r1 + r2, then SUB r4 = r3 - r3 (r3 preloaded stale)
        load(5'd3, 32'd100);
        request(5'd1, 5'd2, 5'd3, 3'h2);
        tick();
        request(5'd3, 5'd3, 5'd4, 3'h3);
        #1;
`ifdef ALU_ISSUE_BYPASS_EN
        chk("hz_ready_bypass", 32'(req_ready), 32'h1);
        tick();
`else
        chk("hz_ready_stall", 32'(req_ready), 32'h0);
        tick();
        chk("hz_valid_drop", 32'(alu_valid), 32'h0);
        chk("hz_ready_back", 32'(req_ready), 32'h1);
        chk("hz_retired_mid", 32'(retired), 32'd2);
        tick();
`endif
        req_valid = 1'b0;
        #1;
        chk("sub_A", alu_A, 32'd8);
        chk("sub_B", alu_B, 32'd8);
        chk("sub_ctrl", 32'(alu_control), 32'h3);
        chk("sub_valid", 32'(alu_valid), 32'h1);
        tick();
        peek("hz_r3", 5'd3, 32'd8);
        peek("sub_r4", 5'd4, 32'd0);
        chk("sub_flags", 32'(flags), 32'h2);
        chk("sub_retired", 32'(retired), 32'd3);

        // Signed overflow: 0x7FFFFFFF + 1
        load(5'd1, 32'h7FFF_FFFF);
        load(5'd2, 32'h1);
        request(5'd1, 5'd2, 5'd5, 3'h2);
        tick();
        req_valid = 1'b0;
        tick();
        peek("ovf_r5", 5'd5, 32'h8000_0000);
        chk("ovf_flags", 32'(flags), 32'h5);
        chk("ovf_retired", 32'(retired), 32'd4);

        // Destination r0 followed by a reader of r0: no stall, r0 stays zero
        request(5'd1, 5'd2, 5'd0, 3'h2);
        tick();
        request(5'd0, 5'd1, 5'd7, 3'h5);
        #1;
        chk("r0_no_stall", 32'(req_ready), 32'h1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("r0_read_A", alu_A, 32'h0);
        chk("r0_read_B", alu_B, 32'h7FFF_FFFF);
        chk("r0_retired", 32'(retired), 32'd5);
        tick();
        peek("r0_zero", 5'd0, 32'h0);
        peek("or_r7", 5'd7, 32'h7FFF_FFFF);
        chk("or_flags", 32'(flags), 32'h0);
        chk("or_retired", 32'(retired), 32'd6);

        // Load and ALU writeback to the same register on one edge: ALU wins
        request(5'd1, 5'd2, 5'd8, 3'h2);
        tick();
        req_valid = 1'b0;
        ld_we     = 1'b1;
        ld_addr   = 5'd8;
        ld_data   = 32'h0000_1234;
        tick();
        ld_we     = 1'b0;
        peek("collide_r8", 5'd8, 32'h8000_0000);
        chk("collide_retired", 32'(retired), 32'd7);

        // Reset while an operation is in flight to r6
        load(5'd6, 32'h55);
        peek("r6_pre", 5'd6, 32'h55);
        request(5'd1, 5'd2, 5'd6, 3'h2);
        tick();
        req_valid = 1'b0;
        #1;
        chk("rst_inflight_valid", 32'(alu_valid), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(alu_valid), 32'h0);
        chk("rst_A", alu_A, 32'h0);
        chk("rst_B", alu_B, 32'h0);
        chk("rst_ctrl", 32'(alu_control), 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_retired", 32'(retired), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        peek("rst_r6", 5'd6, 32'h0);
        tick();
        reset_n = 1'b1;
        #1;
        peek("post_rst_r6", 5'd6, 32'h0);
        peek("post_rst_r8", 5'd8, 32'h0);
        chk("post_rst_retired", 32'(retired), 32'h0);
        chk("post_rst_ready", 32'(req_ready), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
